// File: rtl/silife_max7219_rx.sv
// Receive-side model of a chain of MAX7219 drivers. It deserialises SPI command
// words, commits them to per-device register files and exposes a registered readback port.
module silife_max7219_rx #(
  parameter int CHAIN    = 16,
  parameter int DEV_BITS = $clog2(CHAIN)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                spi_cs,
  input  logic                spi_sck,
  input  logic                spi_mosi,
  output logic                o_dout,
  input  logic [DEV_BITS-1:0] i_dev,
  input  logic [2:0]          i_row,
  output logic [7:0]          o_row,
  output logic [3:0]          o_intensity,
  output logic [2:0]          o_scan_limit,
  output logic [7:0]          o_decode,
  output logic                o_shutdown_n,
  output logic                o_test,
  output logic                o_latch,
  output logic                o_err
);

  localparam int FRAME_BITS = 16 * CHAIN;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  logic [1:0]            cs_sync, sck_sync, mosi_sync;
  logic                  cs_q, sck_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      bit_count;

  logic [7:0] digit      [CHAIN][8];
  logic [3:0] intensity  [CHAIN];
  logic [2:0] scan_limit [CHAIN];
  logic [7:0] decode     [CHAIN];
  logic       shutdown_n [CHAIN];
  logic       test_bit   [CHAIN];

  logic cs_fall, cs_rise, sck_rise, shift_en, commit, abort, dev_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync   <= 2'b11;
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], spi_cs};
      sck_sync  <= {sck_sync[0], spi_sck};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cs_q      <= cs_sync[1];
      sck_q     <= sck_sync[1];
    end
  end

  // The cs-fall cycle is excluded from shifting so that the count clear always wins.
  assign cs_fall  = cs_q & ~cs_sync[1];
  assign cs_rise  = ~cs_q & cs_sync[1];
  assign sck_rise = ~sck_q & sck_sync[1];
  assign shift_en = sck_rise & ~cs_sync[1] & ~cs_q;
  assign commit   = cs_rise && (bit_count == CNT_W'(FRAME_BITS));
  assign abort    = cs_rise && (bit_count != '0) && (bit_count != CNT_W'(FRAME_BITS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bit_count <= '0;
      o_latch   <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_latch <= commit;
      o_err   <= abort;
      if (cs_fall) begin
        bit_count <= '0;
      end else if (shift_en) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], mosi_sync[1]};
        if (bit_count != CNT_W'(FRAME_BITS + 1))
          bit_count <= bit_count + CNT_W'(1);
      end
    end
  end

  assign o_dout = shift_q[FRAME_BITS-1];

  // Device k decodes the k-th word from the bottom of the shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CHAIN; k++) begin
        for (int r = 0; r < 8; r++)
          digit[k][r] <= '0;
        intensity[k]  <= '0;
        scan_limit[k] <= '0;
        decode[k]     <= '0;
        shutdown_n[k] <= 1'b0;
        test_bit[k]   <= 1'b0;
      end
    end else if (commit) begin
      for (int k = 0; k < CHAIN; k++) begin
        case (shift_q[16*k+8 +: 4])
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
            digit[k][3'(shift_q[16*k+8 +: 4] - 4'd1)] <= shift_q[16*k +: 8];
          4'h9: decode[k]     <= shift_q[16*k +: 8];
          4'hA: intensity[k]  <= shift_q[16*k +: 4];
          4'hB: scan_limit[k] <= shift_q[16*k +: 3];
          4'hC: shutdown_n[k] <= shift_q[16*k];
          4'hF: test_bit[k]   <= shift_q[16*k];
          default: ;
        endcase
      end
    end
  end

  if (CHAIN == (1 << DEV_BITS)) begin : g_full_index
    assign dev_ok = 1'b1;
  end else begin : g_partial_index
    assign dev_ok = (i_dev < DEV_BITS'(CHAIN));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_row        <= '0;
      o_intensity  <= '0;
      o_scan_limit <= '0;
      o_decode     <= '0;
      o_shutdown_n <= 1'b0;
      o_test       <= 1'b0;
    end else if (dev_ok) begin
      o_row        <= digit[i_dev][i_row];
      o_intensity  <= intensity[i_dev];
      o_scan_limit <= scan_limit[i_dev];
      o_decode     <= decode[i_dev];
      o_shutdown_n <= shutdown_n[i_dev];
      o_test       <= test_bit[i_dev];
    end else begin
      o_row        <= '0;
      o_intensity  <= '0;
      o_scan_limit <= '0;
      o_decode     <= '0;
      o_shutdown_n <= 1'b0;
      o_test       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_silife_max7219_rx.sv
// Self-checking bench for silife_max7219_rx: table-driven frames plus random frames,
// compared against a per-device register model and a history of shifted bits.
module tb_silife_max7219_rx;

  localparam int CHAIN    = 16;
  localparam int DEV_BITS = 4;
  localparam int FRAME    = 16 * CHAIN;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                spi_cs, spi_sck, spi_mosi;
  logic                o_dout;
  logic [DEV_BITS-1:0] i_dev;
  logic [2:0]          i_row;
  logic [7:0]          o_row;
  logic [3:0]          o_intensity;
  logic [2:0]          o_scan_limit;
  logic [7:0]          o_decode;
  logic                o_shutdown_n, o_test, o_latch, o_err;

  always #5 clk = ~clk;

  silife_max7219_rx #(.CHAIN(CHAIN), .DEV_BITS(DEV_BITS)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .o_dout(o_dout), .i_dev(i_dev), .i_row(i_row),
    .o_row(o_row), .o_intensity(o_intensity), .o_scan_limit(o_scan_limit),
    .o_decode(o_decode), .o_shutdown_n(o_shutdown_n), .o_test(o_test),
    .o_latch(o_latch), .o_err(o_err)
  );

  typedef struct {
    int          dev;
    logic [15:0] word;
    logic [15:0] fill;
    int          nbits;
    int          exp_latch;
    int          exp_err;
    int          pdev;
    int          prow;
    logic [7:0]  pval;
  } vec_t;

  vec_t        vecs [8];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          latch_seen = 0;
  int          err_seen = 0;
  logic [15:0] frame_words [CHAIN];

  logic [7:0] m_row  [CHAIN][8];
  logic [3:0] m_int  [CHAIN];
  logic [2:0] m_scan [CHAIN];
  logic [7:0] m_dec  [CHAIN];
  logic       m_shdn [CHAIN];
  logic       m_test [CHAIN];
  bit         hist [$];

  always @(negedge clk) begin
    if (o_latch) latch_seen++;
    if (o_err) err_seen++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CHAIN; k++) begin
      for (int r = 0; r < 8; r++) m_row[k][r] = 8'h00;
      m_int[k] = 4'h0; m_scan[k] = 3'h0; m_dec[k] = 8'h00;
      m_shdn[k] = 1'b0; m_test[k] = 1'b0;
    end
    hist.delete();
  endtask

  task automatic model_commit();
    int a;
    for (int k = 0; k < CHAIN; k++) begin
      a = int'(frame_words[k][11:8]);
      if (a >= 1 && a <= 8) m_row[k][a-1] = frame_words[k][7:0];
      else if (a == 9)  m_dec[k]  = frame_words[k][7:0];
      else if (a == 10) m_int[k]  = frame_words[k][3:0];
      else if (a == 11) m_scan[k] = frame_words[k][2:0];
      else if (a == 12) m_shdn[k] = frame_words[k][0];
      else if (a == 15) m_test[k] = frame_words[k][0];
    end
  endtask

  task automatic spi_bit(input bit b);
    int n;
    spi_mosi = b;
    repeat (3) @(negedge clk);
    spi_sck = 1'b1;
    hist.push_back(b);
    repeat (3) @(negedge clk);
    spi_sck = 1'b0;
    n = hist.size();
    checkOutput("dout", 16'(o_dout), 16'((n >= FRAME) ? hist[n-FRAME] : 1'b0));
  endtask

  // Sends nbits of the frame held in frame_words, device CHAIN-1 first, MSB first.
  task automatic applyStimulus(input int nbits);
    logic [15:0] w;
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < FRAME) begin
        w = frame_words[CHAIN-1-i/16];
        spi_bit(w[15-(i%16)]);
      end else begin
        spi_bit(1'($urandom_range(0, 1)));
      end
    end
    repeat (3) @(negedge clk);
    spi_cs = 1'b1;
    repeat (6) @(negedge clk);
    if (nbits == FRAME) model_commit();
  endtask

  task automatic read_back(input int d, input int r);
    @(negedge clk);
    i_dev = DEV_BITS'(d);
    i_row = 3'(r);
    @(negedge clk);
  endtask

  task automatic check_all();
    for (int d = 0; d < CHAIN; d++) begin
      for (int r = 0; r < 8; r++) begin
        read_back(d, r);
        checkOutput($sformatf("row d%0d r%0d", d, r), 16'(o_row), 16'(m_row[d][r]));
        if (r == 0) begin
          checkOutput($sformatf("intensity d%0d", d), 16'(o_intensity), 16'(m_int[d]));
          checkOutput($sformatf("scan d%0d", d), 16'(o_scan_limit), 16'(m_scan[d]));
          checkOutput($sformatf("decode d%0d", d), 16'(o_decode), 16'(m_dec[d]));
          checkOutput($sformatf("shdn d%0d", d), 16'(o_shutdown_n), 16'(m_shdn[d]));
          checkOutput($sformatf("test d%0d", d), 16'(o_test), 16'(m_test[d]));
        end
      end
    end
  endtask

  task automatic run_frame(input string name, input int nbits, input int exp_latch, input int exp_err);
    int l0, e0;
    l0 = latch_seen;
    e0 = err_seen;
    applyStimulus(nbits);
    checkOutput({name, " latch"}, 16'(latch_seen - l0), 16'(exp_latch));
    checkOutput({name, " err"}, 16'(err_seen - e0), 16'(exp_err));
  endtask

  initial begin
    int sel, nb;
    vecs[0] = '{dev: 0,  word: 16'h0C01, fill: 16'h0C01, nbits: FRAME,     exp_latch: 1, exp_err: 0, pdev: 5,  prow: 0, pval: 8'h00};
    vecs[1] = '{dev: 3,  word: 16'h03A5, fill: 16'h0000, nbits: FRAME,     exp_latch: 1, exp_err: 0, pdev: 3,  prow: 2, pval: 8'hA5};
    vecs[2] = '{dev: 7,  word: 16'h0155, fill: 16'h0000, nbits: FRAME - 1, exp_latch: 0, exp_err: 1, pdev: 7,  prow: 0, pval: 8'h00};
    vecs[3] = '{dev: 15, word: 16'h0A07, fill: 16'h0B05, nbits: FRAME,     exp_latch: 1, exp_err: 0, pdev: 3,  prow: 2, pval: 8'hA5};
    vecs[4] = '{dev: 0,  word: 16'h0855, fill: 16'h0000, nbits: FRAME + 5, exp_latch: 0, exp_err: 1, pdev: 0,  prow: 7, pval: 8'h00};
    vecs[5] = '{dev: 0,  word: 16'h0855, fill: 16'h0000, nbits: FRAME,     exp_latch: 1, exp_err: 0, pdev: 0,  prow: 7, pval: 8'h55};
    vecs[6] = '{dev: 0,  word: 16'h0000, fill: 16'h0000, nbits: 0,         exp_latch: 0, exp_err: 0, pdev: 0,  prow: 7, pval: 8'h55};
    vecs[7] = '{dev: 2,  word: 16'hF101, fill: 16'h0000, nbits: FRAME,     exp_latch: 1, exp_err: 0, pdev: 2,  prow: 0, pval: 8'h01};

    reset_n = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    i_dev = '0; i_row = '0;
    model_reset();
    repeat (4) @(negedge clk);
    checkOutput("reset latch", 16'(o_latch), 16'h0);
    checkOutput("reset err", 16'(o_err), 16'h0);
    checkOutput("reset dout", 16'(o_dout), 16'h0);
    checkOutput("reset shdn", 16'(o_shutdown_n), 16'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Load state, then discard a partial frame with reset.
    for (int k = 0; k < CHAIN; k++) frame_words[k] = 16'h0C01;
    run_frame("preload", FRAME, 1, 0);
    read_back(9, 0);
    checkOutput("preload shdn d9", 16'(o_shutdown_n), 16'h1);
    begin
      int l0, e0;
      l0 = latch_seen;
      e0 = err_seen;
      for (int k = 0; k < CHAIN; k++) frame_words[k] = 16'(k) | 16'h0100;
      @(negedge clk);
      spi_cs = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 100; i++) spi_bit(1'($urandom_range(0, 1)));
      reset_n = 1'b0;
      spi_cs = 1'b1;
      spi_sck = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("midreset latch", 16'(latch_seen - l0), 16'h0);
      checkOutput("midreset err", 16'(err_seen - e0), 16'h0);
    end
    check_all();

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < CHAIN; k++)
        frame_words[k] = (k == vecs[i].dev) ? vecs[i].word : vecs[i].fill;
      run_frame($sformatf("vec%0d", i), vecs[i].nbits, vecs[i].exp_latch, vecs[i].exp_err);
      read_back(vecs[i].pdev, vecs[i].prow);
      checkOutput($sformatf("vec%0d probe", i), 16'(o_row), 16'(vecs[i].pval));
      if (i == 3) begin
        read_back(15, 0);
        checkOutput("first word intensity d15", 16'(o_intensity), 16'h7);
        read_back(0, 0);
        checkOutput("last word scan d0", 16'(o_scan_limit), 16'h5);
      end
      check_all();
    end

    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < CHAIN; k++)
        frame_words[k] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'($urandom)};
      sel = $urandom_range(0, 5);
      if (sel <= 3) nb = FRAME;
      else if (sel == 4) nb = ($urandom_range(0, 1) == 1) ? FRAME - 1 : FRAME + 2;
      else nb = 0;
      run_frame($sformatf("rand%0d", f), nb, (nb == FRAME) ? 1 : 0, (nb != 0 && nb != FRAME) ? 1 : 0);
      check_all();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
